// File: rtl/vga_timing_pkg.sv
// Shared timing constants and the colour-bar table for the VGA sync generator.
// Defaults describe 640x480@60 on a 25 MHz pixel clock.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CNT_W_DEF    = 10;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Inclusive first/last counter values of each sync pulse.
    localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

    localparam int NUM_BARS = 8;

    // 4:4:4 colour packed as {r, g, b}.
    typedef logic [11:0] rgb_t;

    // Colour of vertical bar idx, left to right; anything past the last bar is black.
    function automatic rgb_t bar_colour(input int unsigned idx);
        case (idx)
            0:       return 12'hFFF; // white
            1:       return 12'hFF0; // yellow
            2:       return 12'h0FF; // cyan
            3:       return 12'h0F0; // green
            4:       return 12'hF0F; // magenta
            5:       return 12'hF00; // red
            6:       return 12'h00F; // blue
            default: return 12'h000; // black
        endcase
    endfunction

endpackage

// File: rtl/vga_test_pattern.sv
// Colour-bar generator: maps a horizontal position to one of eight vertical bars.
// Purely combinational; the caller registers the result so it lines up with x.
// Only instantiated when VGA_TEST_PATTERN_EN is defined.
module vga_test_pattern
    import vga_timing_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF
) (
    input  logic [CNT_W-1:0] i_x,
    input  logic             i_video_on,
    output logic [11:0]      o_rgb
);

    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / NUM_BARS);

    logic [CNT_W-1:0] w_bar;

    // Pick the bar under the beam; blanking forces black.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        o_rgb = '0;
        w_bar = i_x / BAR_W;
        if (i_video_on) begin
            o_rgb = bar_colour(32'(w_bar));
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running x/y counters with registered sync, blanking
// and tick outputs decoded from the next counter values, so every output in a
// cycle describes the x/y presented in that same cycle.
// Optional feature macro: VGA_TEST_PATTERN_EN (colour bars on vga_r/g/b; tied to 0 otherwise).
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             CLK25MHZ,
    input  logic             reset,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_tick,
    output logic             frame_tick,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic SYNC_ON = SYNC_POL;

    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_line_tick;
    logic             r_frame_tick;
    logic [11:0]      r_rgb;

    logic [CNT_W-1:0] w_x_next;
    logic [CNT_W-1:0] w_y_next;
    logic             w_hs_act_next;
    logic             w_vs_act_next;
    logic             w_video_on_next;
    logic [11:0]      w_rgb_next;

    // Next counter position: x wraps at end of line, y advances only on that wrap.
    always_comb begin
        w_x_next = r_x + CNT_W'(1);
        w_y_next = r_y;
        if (r_x == H_LAST) begin
            w_x_next = '0;
            if (r_y == V_LAST) begin
                w_y_next = '0;
            end else begin
                w_y_next = r_y + CNT_W'(1);
            end
        end
    end

    // Decode sync windows and visible area from the position about to be loaded.
    always_comb begin
        w_hs_act_next   = (w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST);
        w_vs_act_next   = (w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST);
        w_video_on_next = (w_x_next < H_VIS) && (w_y_next < V_VIS);
    end

`ifdef VGA_TEST_PATTERN_EN
    vga_test_pattern #(
        .CNT_W    (CNT_W),
        .H_ACTIVE (H_ACTIVE)
    ) u_test_pattern (
        .i_x        (w_x_next),
        .i_video_on (w_video_on_next),
        .o_rgb      (w_rgb_next)
    );
`else
    assign w_rgb_next = '0;
`endif

    // Pixel position counters.
    always_ff @(posedge CLK25MHZ or posedge reset) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
            r_x <= w_x_next;
            r_y <= w_y_next;
        end
    end

    // Registered outputs, aligned with the counters; the reset position emits no ticks.
    always_ff @(posedge CLK25MHZ or posedge reset) begin
        if (reset) begin
            r_hsync      <= ~SYNC_ON;
            r_vsync      <= ~SYNC_ON;
            r_video_on   <= 1'b1;
            r_line_tick  <= 1'b0;
            r_frame_tick <= 1'b0;
            r_rgb        <= '0;
        end else begin
            r_hsync      <= w_hs_act_next ? SYNC_ON : ~SYNC_ON;
            r_vsync      <= w_vs_act_next ? SYNC_ON : ~SYNC_ON;
            r_video_on   <= w_video_on_next;
            r_line_tick  <= (w_x_next == '0);
            r_frame_tick <= (w_x_next == '0) && (w_y_next == '0);
            r_rgb        <= w_rgb_next;
        end
    end

    assign x          = r_x;
    assign y          = r_y;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign video_on   = r_video_on;
    assign line_tick  = r_line_tick;
    assign frame_tick = r_frame_tick;
    assign vga_r      = r_rgb[11:8];
    assign vga_g      = r_rgb[7:4];
    assign vga_b      = r_rgb[3:0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. DUT "a" uses the 640x480 defaults and covers the first
// lines plus a mid-line reset; DUT "b" uses a shrunken geometry (80x31 total) so
// whole frames, vsync and frame_tick periods fit in a short run.
// Every cycle an expected output vector is queued from a position model and
// popped against the DUT after the clock edge.
`timescale 1ns/1ps
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        von;
        logic        lt;
        logic        ft;
        logic [11:0] rgb;
    } obs_t;

    typedef struct packed {
        bit   which;
        obs_t e;
    } sb_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    logic       hs_a, vs_a, von_a, lt_a, ft_a;
    logic [9:0] x_a, y_a;
    logic [3:0] r_a, g_a, b_a;
    logic       hs_b, vs_b, von_b, lt_b, ft_b;
    logic [9:0] x_b, y_b;
    logic [3:0] r_b, g_b, b_b;

    obs_t obs_a, obs_b;
    assign obs_a = {x_a, y_a, hs_a, vs_a, von_a, lt_a, ft_a, r_a, g_a, b_a};
    assign obs_b = {x_b, y_b, hs_b, vs_b, von_b, lt_b, ft_b, r_b, g_b, b_b};

    vga_sync_gen u_a (
        .CLK25MHZ   (clk),
        .reset      (rst_a),
        .hsync      (hs_a),
        .vsync      (vs_a),
        .video_on   (von_a),
        .x          (x_a),
        .y          (y_a),
        .line_tick  (lt_a),
        .frame_tick (ft_a),
        .vga_r      (r_a),
        .vga_g      (g_a),
        .vga_b      (b_a)
    );

    vga_sync_gen #(
        .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (24), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .SYNC_POL (1'b0), .CNT_W (10)
    ) u_b (
        .CLK25MHZ   (clk),
        .reset      (rst_b),
        .hsync      (hs_b),
        .vsync      (vs_b),
        .video_on   (von_b),
        .x          (x_b),
        .y          (y_b),
        .line_tick  (lt_b),
        .frame_tick (ft_b),
        .vga_r      (r_b),
        .vga_g      (g_b),
        .vga_b      (b_b)
    );

    localparam int B_FRAME = 80 * 31;

    int  n_total = 0;
    int  n_bad   = 0;
    int  n_a     = 0;
    int  n_b     = 0;
    int  cyc     = 0;
    sb_t sb_q[$];

    int  first_t, second_t, cnt_hs, cnt_vs, cnt_von, cnt_lt, rel_t;
    bit  found;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] bar_rgb(input int idx);
        logic [11:0] t [8];
        t = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        return (idx >= 0 && idx < 8) ? t[idx] : 12'h000;
    endfunction

    // Expected outputs n clock edges after reset release (n=0: held in reset).
    function automatic obs_t model(input int n, input int ha, input int hf, input int hsn, input int hb,
                                   input int va, input int vf, input int vsn, input int vb);
        obs_t o;
        int   ht, vt, xx, yy;
        ht = ha + hf + hsn + hb;
        vt = va + vf + vsn + vb;
        o = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b1, lt: 1'b0, ft: 1'b0, rgb: 12'h000};
        if (n > 0) begin
            xx    = n % ht;
            yy    = (n / ht) % vt;
            o.x   = 10'(xx);
            o.y   = 10'(yy);
            o.hs  = !(xx >= ha + hf && xx < ha + hf + hsn);
            o.vs  = !(yy >= va + vf && yy < va + vf + vsn);
            o.von = (xx < ha) && (yy < va);
            o.lt  = (xx == 0);
            o.ft  = (xx == 0) && (yy == 0);
`ifdef VGA_TEST_PATTERN_EN
            if (o.von) o.rgb = bar_rgb(xx / (ha / 8));
`endif
        end
        return o;
    endfunction

    function automatic obs_t model_a(input int n);
        return model(n, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic obs_t model_b(input int n);
        return model(n, 64, 4, 8, 4, 24, 2, 2, 3);
    endfunction

    // One clock: queue expectations for both DUTs, clock, then pop and compare.
    task automatic tick();
        sb_t it;
        if (rst_a) n_a = 0; else n_a++;
        if (rst_b) n_b = 0; else n_b++;
        sb_q.push_back('{which: 1'b0, e: model_a(n_a)});
        sb_q.push_back('{which: 1'b1, e: model_b(n_b)});
        @(posedge clk);
        #1;
        cyc++;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            if (it.which) check("sb_b", obs_b, it.e);
            else          check("sb_a", obs_a, it.e);
        end
    endtask

    initial begin
        // Reset state on both instances.
        repeat (3) tick();
        check("a_reset_hsync", hs_a, 1);
        check("a_reset_video_on", von_a, 1);

        // DUT a: release and count from (0,0).
        rst_a = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("a_x_after_release", x_a, i);
        end

        // DUT a: three lines; line_tick period and hsync width of one line.
        first_t = -1; second_t = -1; cnt_hs = 0;
        for (int i = 0; i < 2400; i++) begin
            tick();
            if (lt_a) begin
                if (first_t < 0) first_t = cyc;
                else if (second_t < 0) second_t = cyc;
            end
            if (first_t >= 0 && second_t < 0 && !hs_a) cnt_hs++;
            if (x_a == 10'd640) check("a_blank_at_x640", von_a, 0);
            if (x_a == 10'd656) check("a_hsync_on_at_656", hs_a, 0);
            if (x_a == 10'd752) check("a_hsync_off_at_752", hs_a, 1);
        end
        check("a_line_period", second_t - first_t, 800);
        check("a_hsync_width", cnt_hs, 96);

        // DUT a: async reset at x=700, inside hsync.
        found = 1'b0;
        for (int i = 0; i < 900 && !found; i++) begin
            tick();
            if (x_a == 10'd700) found = 1'b1;
        end
        check("a_reach_x700", found, 1);
        check("a_in_hsync_x700", hs_a, 0);
        #3 rst_a = 1'b1;
        #1;
        check("a_async_reset_now", obs_a, model_a(0));
        repeat (2) tick();
        rst_a = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("a_x_after_midreset", x_a, i);
        end

        // DUT b: full frame from release; frame_tick latency and per-frame counts.
        rst_b = 1'b0;
        rel_t = cyc;
        first_t = -1; second_t = -1;
        cnt_hs = 0; cnt_vs = 0; cnt_von = 0; cnt_lt = 0;
        for (int i = 0; i < 3 * B_FRAME && second_t < 0; i++) begin
            tick();
            if (ft_b) begin
                if (first_t < 0) first_t = cyc;
                else second_t = cyc;
            end
            if (first_t >= 0 && second_t < 0) begin
                if (!hs_b) cnt_hs++;
                if (!vs_b) cnt_vs++;
                if (von_b) cnt_von++;
                if (lt_b) cnt_lt++;
            end
        end
        check("b_first_frame_tick", first_t - rel_t, B_FRAME);
        check("b_frame_period", second_t - first_t, B_FRAME);
        check("b_hsync_per_frame", cnt_hs, 8 * 31);
        check("b_vsync_per_frame", cnt_vs, 2 * 80);
        check("b_video_on_per_frame", cnt_von, 64 * 24);
        check("b_lines_per_frame", cnt_lt, 31);

        // DUT b: async reset at x=70, y=15 (inside hsync), then frame_tick latency.
        found = 1'b0;
        for (int i = 0; i < 2 * B_FRAME && !found; i++) begin
            tick();
            if (x_b == 10'd70 && y_b == 10'd15) found = 1'b1;
        end
        check("b_reach_mid", found, 1);
        #3 rst_b = 1'b1;
        #1;
        check("b_async_reset_now", obs_b, model_b(0));
        tick();
        rst_b = 1'b0;
        rel_t = cyc;
        found = 1'b0;
        for (int i = 0; i < B_FRAME + 10 && !found; i++) begin
            tick();
            if (ft_b) found = 1'b1;
        end
        check("b_frame_tick_seen", found, 1);
        check("b_frame_tick_after_reset", cyc - rel_t, B_FRAME);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
